i2c_req_arbiter: RTL

I2C_REQ_ARBITER -- requirements
Module: i2c_req_arbiter

---
 rtl/i2c_req_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter handing one I2C master to NREQ requesters, with transfer timeout.
// States: IDLE wait for req | GRANT m_start pulse | WAIT transfer in flight | RELEASE drop gnt, advance ptr
module i2c_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [7*NREQ-1:0] req_addr,
    input  logic [NREQ-1:0]   req_rw,
    output logic [NREQ-1:0]   gnt,
    output logic              m_start,
    output logic [6:0]        m_addr,
    output logic              m_rw,
    input  logic              m_done,
    input  logic              m_ack_err,
    output logic              m_abort,
    output logic [NREQ-1:0]   done,
    output logic [NREQ-1:0]   err,
    output logic              busy
);
    localparam int IW = $clog2(NREQ);
    localparam logic [15:0] CNT_MAX = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_WAIT, S_RELEASE} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              m_start_q, m_start_d;
    logic              m_abort_q, m_abort_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [NREQ-1:0]   err_q, err_d;
    logic              busy_q, busy_d;
    logic [6:0]        m_addr_q, m_addr_d;
    logic              m_rw_q, m_rw_d;

    logic              sel_found;
    logic [IW-1:0]     sel_idx;
    logic [IW-1:0]     cand;
    logic              timeout_hit;

    // Scan downward so the requester closest to rr_ptr is the last (winning) assignment.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = rr_ptr_q + IW'(k);
            if (req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign timeout_hit = (cnt_q == CNT_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            m_start_q <= 1'b0;
            m_abort_q <= 1'b0;
            done_q    <= '0;
            err_q     <= '0;
            busy_q    <= 1'b0;
            m_addr_q  <= '0;
            m_rw_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            m_start_q <= m_start_d;
            m_abort_q <= m_abort_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            m_addr_q  <= m_addr_d;
            m_rw_q    <= m_rw_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (sel_found) state_d = S_GRANT;
            S_GRANT:   state_d = S_WAIT;
            S_WAIT:    if (m_done || timeout_hit) state_d = S_RELEASE;
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the upcoming state, so they line up with state_q.
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        m_start_d = 1'b0;
        m_abort_d = 1'b0;
        done_d    = '0;
        err_d     = '0;
        m_addr_d  = m_addr_q;
        m_rw_d    = m_rw_q;
        busy_d    = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (sel_found) begin
                    idx_d     = sel_idx;
                    m_addr_d  = req_addr[int'(sel_idx)*7 +: 7];
                    m_rw_d    = req_rw[sel_idx];
                    gnt_d     = NREQ'(1) << sel_idx;
                    m_start_d = 1'b1;
                end
            end
            S_GRANT: cnt_d = '0;
            S_WAIT: begin
                if (m_done) begin
                    done_d = NREQ'(1) << idx_q;
                    if (m_ack_err) err_d = NREQ'(1) << idx_q;
                end else if (timeout_hit) begin
                    err_d     = NREQ'(1) << idx_q;
                    m_abort_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_RELEASE: begin
                gnt_d    = '0;
                rr_ptr_d = idx_q + IW'(1);
            end
            default: ;
        endcase
    end

    assign gnt     = gnt_q;
    assign m_start = m_start_q;
    assign m_abort = m_abort_q;
    assign done    = done_q;
    assign err     = err_q;
    assign busy    = busy_q;
    assign m_addr  = m_addr_q;
    assign m_rw    = m_rw_q;

endmodule
